ahb_dphase_mux: RTL and testbench

Parametrised successor to the one-hot channel mux used in the AHB interconnect. The combinational select is replaced by a registered data-phase select captured at the address/data-phase boundary (HREADY high). Response payload therefore stays routed to the right channel across wait states. Adds multi-hot select detection, an idle default payload and a per-transfer wait-state counter. Sits on the response return path between N slave channels and one master port.

---
 rtl/ahb_dphase_mux_if.sv | 44 ++++
 rtl/ahb_dphase_mux.sv | 134 +++++++++++++
 tb/tb_ahb_dphase_mux.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ahb_dphase_mux_if.sv
// ---------------------------------------------------------------------------
// ahb_dphase_mux_if
// Bundle of the response-return signals around ahb_dphase_mux.
//
// Signals:
//   sel_addr      address-phase channel select (one-hot or zero)
//   hready_in     bus HREADY; high ends the data phase and accepts a new address phase
//   payload_in    per-channel response payload, CHANNEL_NUM x PAYLOAD
//   payload_out   payload of the channel owning the data phase
//   dsel          registered data-phase select
//   dphase_active a channel owns the current data phase
//   sel_err       one-cycle pulse when a multi-hot select was captured
//   wait_cnt      saturating wait-state count of the current data phase
//   timeout       data-phase timeout flag (constant 0 unless the timeout build is used)
//
// Modports:
//   master  bus side: drives selects, HREADY and channel payloads
//   slave   mux side: drives the routed payload and status
// ---------------------------------------------------------------------------
interface ahb_dphase_mux_if #(
  parameter int CHANNEL_NUM = 2,
  parameter int PAYLOAD     = 34,
  parameter int WAIT_W      = 8
);
  logic [CHANNEL_NUM-1:0]              sel_addr;
  logic                                hready_in;
  logic [CHANNEL_NUM-1:0][PAYLOAD-1:0] payload_in;
  logic [PAYLOAD-1:0]                  payload_out;
  logic [CHANNEL_NUM-1:0]              dsel;
  logic                                dphase_active;
  logic                                sel_err;
  logic [WAIT_W-1:0]                   wait_cnt;
  logic                                timeout;

  modport master (
    output sel_addr, hready_in, payload_in,
    input  payload_out, dsel, dphase_active, sel_err, wait_cnt, timeout
  );

  modport slave (
    input  sel_addr, hready_in, payload_in,
    output payload_out, dsel, dphase_active, sel_err, wait_cnt, timeout
  );
endinterface

// File: rtl/ahb_dphase_mux.sv
// ---------------------------------------------------------------------------
// ahb_dphase_mux
// Response-path channel mux with a registered data-phase select. The
// address-phase select is captured when HREADY is high, so the response of
// the slave that owns the data phase stays routed across wait states.
//
// Ports:
//   HCLK     clock
//   HRESETn  asynchronous active-low reset
//   bus      ahb_dphase_mux_if.slave (select, HREADY, payloads in;
//            routed payload, dsel, dphase_active, sel_err, wait_cnt, timeout out)
//
// Optional build macro:
//   AHB_DPHASE_MUX_TIMEOUT_EN  adds parameter TIMEOUT (< 2^WAIT_W). A data
//   phase stalled for TIMEOUT wait states raises timeout and masks the
//   payload to IDLE_PAYLOAD until the next HREADY edge. Without the macro
//   timeout is constant 0.
// ---------------------------------------------------------------------------
module ahb_dphase_mux #(
  parameter int                 CHANNEL_NUM  = 2,
  parameter int                 PAYLOAD      = 34,
  parameter logic [PAYLOAD-1:0] IDLE_PAYLOAD = '0,
  parameter int                 WAIT_W       = 8
`ifdef AHB_DPHASE_MUX_TIMEOUT_EN
  , parameter int               TIMEOUT      = 16
`endif
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  ahb_dphase_mux_if.slave      bus
);

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_t;

  state_t                 state_reg;
  logic [CHANNEL_NUM-1:0] dsel_reg;
  logic                   sel_err_reg;
  logic [WAIT_W-1:0]      wait_cnt_reg;

  logic                   sel_nonzero;
  logic                   sel_onehot;
  logic                   sel_multi;
  logic                   wait_sat;
  logic [WAIT_W-1:0]      wait_inc;

  // x & (x-1) clears the lowest set bit: zero result means at most one bit set.
  assign sel_nonzero = |bus.sel_addr;
  assign sel_onehot  = sel_nonzero &&
                       ((bus.sel_addr & (bus.sel_addr - CHANNEL_NUM'(1))) == '0);
  assign sel_multi   = sel_nonzero && !sel_onehot;

  assign wait_sat = &wait_cnt_reg;
  assign wait_inc = wait_cnt_reg + WAIT_W'(1);

`ifdef AHB_DPHASE_MUX_TIMEOUT_EN
  logic timeout_reg;
`endif

  // Single state machine: the state register and dsel move together; status
  // outputs are registered alongside.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg    <= IDLE;
      dsel_reg     <= '0;
      sel_err_reg  <= 1'b0;
      wait_cnt_reg <= '0;
`ifdef AHB_DPHASE_MUX_TIMEOUT_EN
      timeout_reg  <= 1'b0;
`endif
    end else if (bus.hready_in) begin
      // Data/address phase boundary: capture the new owner.
      wait_cnt_reg <= '0;
      sel_err_reg  <= sel_multi;
`ifdef AHB_DPHASE_MUX_TIMEOUT_EN
      timeout_reg  <= 1'b0;
`endif
      if (sel_onehot) begin
        state_reg <= DATA;
        dsel_reg  <= bus.sel_addr;
      end else begin
        // Zero and multi-hot selects both leave no owner.
        state_reg <= IDLE;
        dsel_reg  <= '0;
      end
    end else begin
      // Wait state: owner holds, sel_addr is not a valid address phase.
      sel_err_reg <= 1'b0;
      if (state_reg == DATA && !wait_sat) begin
        wait_cnt_reg <= wait_inc;
`ifdef AHB_DPHASE_MUX_TIMEOUT_EN
        if (wait_inc == WAIT_W'(TIMEOUT)) begin
          timeout_reg <= 1'b1;
        end
`endif
      end
    end
  end

  // AND-OR payload mux; dsel is one-hot or zero, so at most one term survives.
  logic [CHANNEL_NUM-1:0][PAYLOAD-1:0] masked;
  logic [PAYLOAD-1:0]                  routed;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNEL_NUM; gi++) begin : g_mask
      assign masked[gi] = bus.payload_in[gi] & {PAYLOAD{dsel_reg[gi]}};
    end
  endgenerate

  always_comb begin
    routed = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      routed = routed | masked[i];
    end
  end

`ifdef AHB_DPHASE_MUX_TIMEOUT_EN
  // A timed-out slave is masked; dsel stays so the owner remains visible.
  assign bus.payload_out = (dsel_reg == '0 || timeout_reg) ? IDLE_PAYLOAD : routed;
  assign bus.timeout     = timeout_reg;
`else
  assign bus.payload_out = (dsel_reg == '0) ? IDLE_PAYLOAD : routed;
  assign bus.timeout     = 1'b0;
`endif

  assign bus.dsel          = dsel_reg;
  assign bus.dphase_active = (state_reg == DATA);
  assign bus.sel_err       = sel_err_reg;
  assign bus.wait_cnt      = wait_cnt_reg;

endmodule

// File: tb/tb_ahb_dphase_mux.sv
// ---------------------------------------------------------------------------
// tb_ahb_dphase_mux
// Directed bench for ahb_dphase_mux with CHANNEL_NUM=4, PAYLOAD=34, WAIT_W=4
// and a non-zero IDLE_PAYLOAD; TIMEOUT=5 when AHB_DPHASE_MUX_TIMEOUT_EN is set.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_ahb_dphase_mux;

    localparam int          CN     = 4;
    localparam int          PW     = 34;
    localparam int          WW     = 4;
    localparam logic [33:0] IDLE_P = 34'h2_AAAA_5555;

    logic HCLK;
    logic HRESETn;
    int   checks;
    int   errors;

    ahb_dphase_mux_if #(.CHANNEL_NUM(CN), .PAYLOAD(PW), .WAIT_W(WW)) bus ();

    ahb_dphase_mux #(
        .CHANNEL_NUM (CN),
        .PAYLOAD     (PW),
        .IDLE_PAYLOAD(IDLE_P),
        .WAIT_W      (WW)
`ifdef AHB_DPHASE_MUX_TIMEOUT_EN
        , .TIMEOUT   (5)
`endif
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end else begin
            $display("PASS %s: observed=%0h", tag, obs);
        end
    endtask

    initial begin
        logic [33:0] exp_pay;
        logic [3:0]  exp_cnt;
        logic        exp_to;

        checks = 0;
        errors = 0;
        HRESETn = 1'b0;
        bus.sel_addr  = 4'b0000;
        bus.hready_in = 1'b1;
        bus.payload_in[0] = 34'h1;
        bus.payload_in[1] = 34'h2;
        bus.payload_in[2] = 34'h3;
        bus.payload_in[3] = 34'h3_0000_0004;

        tick();
        tick();
        check("rst_dsel", bus.dsel, 4'b0000);
        check("rst_active", bus.dphase_active, 1'b0);
        check("rst_sel_err", bus.sel_err, 1'b0);
        check("rst_wait_cnt", bus.wait_cnt, 4'd0);
        check("rst_timeout", bus.timeout, 1'b0);
        check("rst_payload", bus.payload_out, IDLE_P);
        HRESETn = 1'b1;
        tick();
        check("idle_payload", bus.payload_out, IDLE_P);

        bus.sel_addr = 4'b0001;
        tick();
        check("pipe1_dsel", bus.dsel, 4'b0001);
        check("pipe1_active", bus.dphase_active, 1'b1);
        check("pipe1_payload", bus.payload_out, 34'h1);
        bus.sel_addr = 4'b0100;
        tick();
        check("pipe2_dsel", bus.dsel, 4'b0100);
        check("pipe2_payload", bus.payload_out, 34'h3);
        bus.payload_in[2] = 34'h1_2345_6789;
        #1;
        check("pipe2_comb_payload", bus.payload_out, 34'h1_2345_6789);
        bus.payload_in[2] = 34'h3;

        bus.sel_addr = 4'b0010;
        tick();
        check("ws_dsel", bus.dsel, 4'b0010);
        bus.hready_in = 1'b0;
        bus.sel_addr  = 4'b1000;
        tick();
        check("ws1_dsel", bus.dsel, 4'b0010);
        check("ws1_cnt", bus.wait_cnt, 4'd1);
        check("ws1_payload", bus.payload_out, 34'h2);
        tick();
        check("ws2_cnt", bus.wait_cnt, 4'd2);
        tick();
        check("ws3_cnt", bus.wait_cnt, 4'd3);
        check("ws3_dsel", bus.dsel, 4'b0010);
        bus.hready_in = 1'b1;
        tick();
        check("ws_end_dsel", bus.dsel, 4'b1000);
        check("ws_end_cnt", bus.wait_cnt, 4'd0);
        check("ws_end_payload", bus.payload_out, 34'h3_0000_0004);

        bus.sel_addr = 4'b0110;
        tick();
        check("mh_sel_err", bus.sel_err, 1'b1);
        check("mh_dsel", bus.dsel, 4'b0000);
        check("mh_active", bus.dphase_active, 1'b0);
        check("mh_payload", bus.payload_out, IDLE_P);
        bus.sel_addr = 4'b0000;
        tick();
        check("mh_pulse_end", bus.sel_err, 1'b0);
        bus.sel_addr = 4'b1100;
        tick();
        check("mh_b2b_1", bus.sel_err, 1'b1);
        bus.sel_addr = 4'b0011;
        tick();
        check("mh_b2b_2", bus.sel_err, 1'b1);
        bus.hready_in = 1'b0;
        bus.sel_addr  = 4'b1111;
        tick();
        check("mh_stall_sel_err", bus.sel_err, 1'b0);
        tick();
        check("idle_stall_cnt", bus.wait_cnt, 4'd0);
        check("idle_stall_dsel", bus.dsel, 4'b0000);

        bus.hready_in = 1'b1;
        bus.sel_addr  = 4'b0001;
        tick();
        bus.hready_in = 1'b0;
        bus.sel_addr  = 4'b0000;
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp_cnt = (i > 15) ? 4'd15 : 4'(i);
`ifdef AHB_DPHASE_MUX_TIMEOUT_EN
            exp_to  = (i >= 5);
            exp_pay = (i >= 5) ? IDLE_P : 34'h1;
`else
            exp_to  = 1'b0;
            exp_pay = 34'h1;
`endif
            check("sat_cnt", bus.wait_cnt, exp_cnt);
            check("sat_timeout", bus.timeout, exp_to);
            check("sat_payload", bus.payload_out, exp_pay);
        end
        check("sat_dsel", bus.dsel, 4'b0001);
        bus.hready_in = 1'b1;
        tick();
        check("sat_end_cnt", bus.wait_cnt, 4'd0);
        check("sat_end_timeout", bus.timeout, 1'b0);
        check("sat_end_dsel", bus.dsel, 4'b0000);

        bus.sel_addr = 4'b0100;
        tick();
        bus.hready_in = 1'b0;
        bus.sel_addr  = 4'b0000;
        repeat (4) tick();
        check("to4_timeout", bus.timeout, 1'b0);
        check("to4_payload", bus.payload_out, 34'h3);
        tick();
`ifdef AHB_DPHASE_MUX_TIMEOUT_EN
        check("to5_timeout", bus.timeout, 1'b1);
        check("to5_payload", bus.payload_out, IDLE_P);
`else
        check("to5_timeout", bus.timeout, 1'b0);
        check("to5_payload", bus.payload_out, 34'h3);
`endif
        check("to5_dsel", bus.dsel, 4'b0100);
        check("to5_cnt", bus.wait_cnt, 4'd5);
        bus.hready_in = 1'b1;
        tick();
        check("to_clear", bus.timeout, 1'b0);
        check("to_clear_dsel", bus.dsel, 4'b0000);

        bus.sel_addr = 4'b0010;
        tick();
        bus.hready_in = 1'b0;
        tick();
        check("mid_pre_cnt", bus.wait_cnt, 4'd1);
        #2;
        HRESETn = 1'b0;
        #1;
        check("async_dsel", bus.dsel, 4'b0000);
        check("async_active", bus.dphase_active, 1'b0);
        check("async_cnt", bus.wait_cnt, 4'd0);
        check("async_payload", bus.payload_out, IDLE_P);
        tick();
        HRESETn = 1'b1;
        bus.sel_addr = 4'b0001;
        tick();
        check("post_rst_stall_dsel", bus.dsel, 4'b0000);
        bus.hready_in = 1'b1;
        tick();
        check("post_rst_capture", bus.dsel, 4'b0001);
        check("post_rst_payload", bus.payload_out, 34'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
